// File: rtl/shift_reader_pkg.sv
// Shared definitions for the 74HC165-style serial input reader.
// Chain bit order is MSB first, matching the output shifter.
package shift_reader_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_t;

  // Counter width for a down-counter spanning n values, never below 1 bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_reader_if.sv
// Capture request/result and chain strobe signals for shift_reader.
// master is the core/board side, slave is the reader itself.
interface shift_reader_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             sdata_in;
  logic             load_l;
  logic             sclk;
  logic [WIDTH-1:0] parallel_out;
  logic             valid;
  logic             busy;

  modport master (
    output start,
    output sdata_in,
    input  load_l,
    input  sclk,
    input  parallel_out,
    input  valid,
    input  busy
  );

  modport slave (
    input  start,
    input  sdata_in,
    output load_l,
    output sclk,
    output parallel_out,
    output valid,
    output busy
  );

endinterface

// File: rtl/shift_reader.sv
// Serial reader for a 165-style PISO chain: load, settle, then WIDTH-1 sclk
// pulses, sampling MSB first; publishes the word with a one-cycle valid.
module shift_reader
  import shift_reader_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic          clk,
  input  logic          rst,
  shift_reader_if.slave bus
);

  localparam int DW = cnt_bits(CLK_DIV);
  localparam int BW = cnt_bits(WIDTH);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             load_l_q, load_l_d;
  logic             sclk_q, sclk_d;
  logic             phase_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      pout_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      load_l_q <= 1'b1;
      sclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      pout_q   <= pout_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      load_l_q <= load_l_d;
      sclk_q   <= sclk_d;
    end
  end

  always_comb begin
    phase_end = (div_q == '0);
    state_d   = state_q;
    div_d     = phase_end ? DIV_MAX : div_q - 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pout_d    = pout_q;
    valid_d   = 1'b0;
    busy_d    = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        div_d  = DIV_MAX;
        busy_d = bus.start;
        if (bus.start) begin
          state_d = ST_LOAD;
          bit_d   = BIT_MAX;
        end
      end
      ST_LOAD: begin
        if (phase_end) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (phase_end) begin
          shreg_d = {shreg_q[WIDTH-2:0], bus.sdata_in};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_end) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (phase_end) begin
          // Left shift places the first-sampled bit at WIDTH-1 once all bits are in.
          shreg_d = {shreg_q[WIDTH-2:0], bus.sdata_in};
          bit_d   = bit_q - 1'b1;
          state_d = (bit_q == BIT_ONE) ? ST_DONE : ST_HIGH;
        end
      end
      ST_DONE: begin
        div_d   = DIV_MAX;
        pout_d  = shreg_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels follow the state being entered so each phase lasts CLK_DIV clocks.
    load_l_d = (state_d != ST_LOAD);
    sclk_d   = (state_d == ST_HIGH);
  end

  assign bus.load_l       = load_l_q;
  assign bus.sclk         = sclk_q;
  assign bus.parallel_out = pout_q;
  assign bus.valid        = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_shift_reader.sv
// Bench for shift_reader: 165-chain models, timing-based reference model with a
// per-cycle compare, directed captures and randomized start/word/reset stimulus.
module tb_shift_reader;

  localparam int W = 32;
  localparam int D = 4;
  localparam int L = (2 + 2 * (W - 1)) * D + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_reader_if #(.WIDTH(W)) bus ();
  shift_reader_if #(.WIDTH(8)) bus8 ();

  shift_reader #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  shift_reader #(.WIDTH(8), .CLK_DIV(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // 165 chain: parallel load while load_l is low, shift toward Q7 on sclk rise.
  logic [W-1:0] word  = '0;
  logic [W-1:0] chain = '0;
  always @(posedge bus.sclk or negedge bus.load_l)
    if (!bus.load_l) chain <= word;
    else             chain <= {chain[W-2:0], 1'b0};
  assign bus.sdata_in = chain[W-1];

  logic [7:0] word8  = '0;
  logic [7:0] chain8 = '0;
  always @(posedge bus8.sclk or negedge bus8.load_l)
    if (!bus8.load_l) chain8 <= word8;
    else              chain8 <= {chain8[6:0], 1'b0};
  assign bus8.sdata_in = chain8[7];

  int sclk_rises  = 0;
  int sclk8_rises = 0;
  int valid_seen  = 0;
  always @(posedge bus.sclk)  sclk_rises++;
  always @(posedge bus8.sclk) sclk8_rises++;
  always @(negedge clk) if (bus.valid === 1'b1) valid_seen++;

  // Reference: a capture is a timeline of L+1 clocks measured from the accepting edge.
  bit           m_armed  = 1'b0;
  bit           m_active = 1'b0;
  int           m_rel    = 0;
  logic [W-1:0] m_snap   = '0;
  logic [W-1:0] m_pout   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_pout   = '0;
      m_armed  = 1'b1;
    end else begin
      if (m_active) begin
        m_rel++;
        if (m_rel == L)          m_pout   = m_snap;
        else if (m_rel == L + 1) m_active = 1'b0;
      end
      if (!m_active && bus.start) begin
        m_active = 1'b1;
        m_rel    = 0;
        m_snap   = word;
      end
    end
  end

  function automatic bit exp_sclk(input int r);
    return (r >= 2 * D) && (r < 2 * D + 2 * (W - 1) * D) && (((r - 2 * D) / D) % 2 == 0);
  endfunction

  always @(negedge clk) begin
    if (m_armed) begin
      check("busy",         32'(bus.busy),   32'(m_active));
      check("load_l",       32'(bus.load_l), 32'(!(m_active && m_rel < D)));
      check("sclk",         32'(bus.sclk),   32'(m_active && exp_sclk(m_rel)));
      check("valid",        32'(bus.valid),  32'(m_active && m_rel == L));
      check("parallel_out", bus.parallel_out, m_pout);
    end
  end

  task automatic capture(input logic [W-1:0] w, input bit poke);
    int v0, r0, n;
    @(negedge clk);
    word = w;
    bus.start = 1'b1;
    v0 = valid_seen;
    r0 = sclk_rises;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      bus.start = poke && (n == 10 || n == 200);
    end
    bus.start = 1'b0;
    check("latency", 32'(n), 32'd257);
    check("word", bus.parallel_out, w);
    check("sclk_rises", 32'(sclk_rises - r0), 32'd31);
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    if (poke) repeat (300) @(negedge clk);
    check("valid_count", 32'(valid_seen - v0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, v0;
    logic [16:0] sv, lv;
    logic [W-1:0] exp_w;

    bus.start  = 1'b0;
    bus8.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_load_l", 32'(bus.load_l), 32'd1);
    check("rst_sclk",   32'(bus.sclk),   32'd0);
    check("rst_pout",   bus.parallel_out, 32'd0);
    check("rst_valid",  32'(bus.valid),  32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Small chain, single-clock phases.
    word8 = 8'hC3;
    bus8.start = 1'b1;
    v0 = sclk8_rises;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    sv = '0;
    lv = '0;
    sv[0] = bus8.sclk;
    lv[0] = bus8.load_l;
    while (bus8.valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n <= 16) begin
        sv[n] = bus8.sclk;
        lv[n] = bus8.load_l;
      end
    end
    check("w8_latency", 32'(n), 32'd17);
    check("w8_word", 32'(bus8.parallel_out), 32'h0000_00C3);
    check("w8_sclk_pattern", 32'(sv), 32'h0000_5554);
    check("w8_load_pattern", 32'(lv), 32'h0001_FFFE);
    check("w8_sclk_rises", 32'(sclk8_rises - v0), 32'd7);
    @(negedge clk);
    check("w8_busy_after", 32'(bus8.busy), 32'd0);

    capture(32'hDEAD_BEEF, 1'b0);
    capture(32'h0000_0001, 1'b0);
    capture(32'h8000_0000, 1'b0);
    capture(32'h0F0F_3C3C, 1'b1);

    // Abort mid-capture.
    @(negedge clk);
    word = 32'hFFFF_FFFF;
    bus.start = 1'b1;
    v0 = valid_seen;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_load_l", 32'(bus.load_l), 32'd1);
    check("abort_sclk",   32'(bus.sclk),   32'd0);
    check("abort_busy",   32'(bus.busy),   32'd0);
    check("abort_pout",   bus.parallel_out, 32'd0);
    repeat (300) @(negedge clk);
    check("abort_no_valid", 32'(valid_seen - v0), 32'd0);
    capture(32'h1234_5678, 1'b0);

    // start held high: back-to-back captures with alternating chain contents.
    @(negedge clk);
    word = 32'hA5A5_A5A5;
    bus.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.valid !== 1'b1 && n < 400);
      check("b2b_period", 32'(n), 32'd258);
      check("b2b_word", bus.parallel_out, exp_w);
      word = (k % 2 == 0) ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
      if (k == 3) bus.start = 1'b0;
    end
    repeat (300) @(negedge clk);

    // Randomized starts, chain words and occasional resets, checked by the model.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 2999) == 0);
      if (m_active && m_rel >= D && m_rel < L && $urandom_range(0, 9) == 0)
        word = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (300) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
